// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types and constants for the elastic pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_NDATA  = 2;
  localparam int unsigned DEF_CTRL_W = 3;
  localparam int unsigned DEF_WA_W   = 4;
  localparam int unsigned CNT_W      = 32;

  // Saturating increment used by the performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_perf_cnt.sv
// Stall / bubble event counters for pipe_stage_elastic (falling-edge, saturating).
module pipe_perf_cnt
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  // Next counts: a stall is a held output, a bubble is an empty output.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready) stall_d = sat_inc(stall_q);
    if (!out_valid)              bubble_d = sat_inc(bubble_q);
  end

  // Counter registers; flush intentionally does not reach here.
  always_ff @(negedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic (skid) pipeline register, updating on the falling clock edge.
// Optional build macro PIPE_STAGE_PERF_EN adds stall_cnt / bubble_cnt outputs.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NDATA  = DEF_NDATA,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned WA_W   = DEF_WA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [NDATA*DATA_W-1:0] in_data,
  input  logic [WA_W-1:0]         in_wa,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [NDATA*DATA_W-1:0] out_data,
  output logic [WA_W-1:0]         out_wa
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
`endif
);

  localparam int unsigned PAY_W = NDATA * DATA_W;

  state_e            state_q, state_d;
  logic              in_ready_q, out_valid_q;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [PAY_W-1:0]  main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [WA_W-1:0]   main_wa_q, main_wa_d, skid_wa_q, skid_wa_d;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  // Occupancy transitions; main ctrl is zeroed whenever the stage empties so
  // out_ctrl is a bubble without any output gating logic.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    main_wa_d   = main_wa_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    skid_wa_d   = skid_wa_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d     = ONE;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
          main_wa_d   = in_wa;
        end
      end
      ONE: begin
        if (in_fire) begin
          if (out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_wa_d   = in_wa;
          end else begin
            state_d     = TWO;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            skid_wa_d   = in_wa;
          end
        end else if (out_fire) begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d     = ONE;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          main_wa_d   = skid_wa_q;
        end
      end
      default: begin
        state_d     = EMPTY;
        main_ctrl_d = '0;
      end
    endcase
    // Flush wins over every transfer; the visible data/wa simply hold.
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      main_data_d = main_data_q;
      main_wa_d   = main_wa_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      skid_wa_d   = skid_wa_q;
    end
  end

  // State and entry registers; handshake flags are registered from next state.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      main_wa_q   <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_wa_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      main_wa_q   <= main_wa_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_wa_q   <= skid_wa_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign out_wa    = main_wa_q;

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt u_perf (
    .clk        (clk),
    .rst        (rst),
    .out_valid  (out_valid_q),
    .out_ready  (out_ready),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );
`endif

endmodule
